// File: rtl/ifm_pack_128bit_writer.sv
// Packs a stream of 32-bit IFM words into 128-bit BRAM lines written from a base line address.
// Optional build macro IFM_PACK_BYTE_SWAP_EN byte-reverses each word before lane insertion.
module ifm_pack_128bit_writer #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              wr_rd_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [127:0]      data_in,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   line_ptr_q, line_ptr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [1:0]          lane_q, lane_d;
  logic [127:0]        pack_q, pack_d;
  logic                s_ready_q, s_ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [127:0]        data_in_q, data_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [31:0]         word_in;
  logic [127:0]        merged;
  logic                last_word;
  logic                line_full;

`ifdef IFM_PACK_BYTE_SWAP_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_swap
    assign word_in[8*gi +: 8] = s_data[8*(3-gi) +: 8];
  end
`else
  assign word_in = s_data;
`endif

  assign last_word = (remaining_q == CNT_W'(1));
  assign line_full = (lane_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    line_ptr_d  = line_ptr_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    s_ready_d   = s_ready_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    data_in_d   = data_in_q;
    done_d      = 1'b0;
    merged      = pack_q;
    merged[{lane_q, 5'b0} +: 32] = word_in;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            line_ptr_d  = base_addr;
            remaining_d = num_words;
            lane_d      = 2'd0;
            pack_d      = '0;
            s_ready_d   = 1'b1;
            state_d     = FILL;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      FILL: begin
        if (s_valid && s_ready_q) begin
          remaining_d = remaining_q - 1'b1;
          // A closing word goes straight to the write bus; the pack restarts empty.
          if (line_full || last_word) begin
            wr_en_d    = 1'b1;
            data_in_d  = merged;
            wr_addr_d  = line_ptr_q;
            line_ptr_d = line_ptr_q + 1'b1;
            lane_d     = 2'd0;
            pack_d     = '0;
          end else begin
            lane_d = lane_q + 1'b1;
            pack_d = merged;
          end
          if (last_word) begin
            s_ready_d = 1'b0;
            state_d   = FLUSH;
          end
        end
      end
      FLUSH: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_ptr_q  <= '0;
      remaining_q <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      s_ready_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      data_in_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_ptr_q  <= line_ptr_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      s_ready_q   <= s_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      data_in_q   <= data_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign wr_rd_en = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign data_in  = data_in_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ifm_pack_128bit_writer.sv
// Self-checking bench for ifm_pack_128bit_writer: directed and randomized transfers
// checked against a line-by-line packing model.
module tb_ifm_pack_128bit_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [19:0]  num_words = '0;
  logic         s_valid = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_ready;
  logic         wr_rd_en;
  logic [31:0]  wr_addr;
  logic [127:0] data_in;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0]  words[$];
  logic [31:0]  wq_addr[$];
  logic [127:0] wq_data[$];
  int           wq_cyc[$];
  int           dq_cyc[$];

  ifm_pack_128bit_writer #(.ADDR_W(32), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wr_rd_en(wr_rd_en), .wr_addr(wr_addr),
    .data_in(data_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write/done monitor, sampled mid-cycle; label = cycle in which the output is visible.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_rd_en) begin
        wq_addr.push_back(wr_addr);
        wq_data.push_back(data_in);
        wq_cyc.push_back(cyc);
      end
      if (done) dq_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] xf(input logic [31:0] w);
`ifdef IFM_PACK_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); dq_cyc.delete();
  endtask

  task automatic fill_rand(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // Runs one transfer of the words in 'words', then checks every write against the model.
  task automatic run_xfer(input logic [31:0] base, input int vpct, input bit poke_start);
    int n, idx, guard, c, start_cyc, nlines, last_idx;
    bit rdy;
    int hs[$];
    logic [127:0] exp_data;
    logic [31:0]  exp_addr;
    n = words.size();
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_words = n[19:0];
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; guard = 0;
    while (idx < n && guard < 2000) begin
      s_valid = ($urandom_range(99) < vpct);
      s_data  = words[idx];
      if (poke_start && idx == n/2) begin
        start = 1'b1; base_addr = ~base; num_words = 20'd3;
      end
      chk("s_ready_during_fill", s_ready, 1'b1);
      c = cyc; rdy = s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (s_valid && rdy) begin hs.push_back(c); idx++; end
      guard++;
    end
    s_valid = 1'b0;
    if (guard >= 2000) chk("input_timeout", 1'b0, 1'b1);
    guard = 0;
    while (dq_cyc.size() == 0 && guard < 12) begin
      @(posedge clk); #1; guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    nlines = (n + 3) / 4;
    chk("write_count", wq_addr.size(), nlines);
    chk("done_count", dq_cyc.size(), 1);
    if (n == 0) begin
      if (dq_cyc.size() > 0) chk("done_cycle_zero", dq_cyc[0], start_cyc + 1);
    end else begin
      if (dq_cyc.size() > 0) chk("done_cycle", dq_cyc[0], hs[n-1] + 2);
      for (int k = 0; k < nlines && k < wq_addr.size(); k++) begin
        exp_addr = base + k;
        exp_data = '0;
        for (int j = 0; j < 4; j++)
          if (4*k + j < n) exp_data[32*j +: 32] = xf(words[4*k + j]);
        last_idx = (4*k + 3 < n) ? 4*k + 3 : n - 1;
        chk("wr_addr", wq_addr[k], exp_addr);
        chk("data_in", wq_data[k], exp_data);
        chk("write_latency", wq_cyc[k], hs[last_idx] + 1);
        if (k == nlines - 1) begin
          chk("wr_addr_hold", wr_addr, exp_addr);
          chk("data_in_hold", data_in, exp_data);
        end
      end
    end
    chk("busy_after", busy, 1'b0);
    chk("s_ready_after", s_ready, 1'b0);
    chk("wr_en_after", wr_rd_en, 1'b0);
    $display("[TB] xfer base=%h n=%0d writes=%0d done=%0d", base, n, wq_addr.size(), dq_cyc.size());
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_wr_en", wr_rd_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_data_in", data_in, 128'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Full line with known words
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_xfer(32'h10, 100, 1'b0);
`ifndef IFM_PACK_BYTE_SWAP_EN
    if (wq_data.size() > 0)
      chk("full_line_literal", wq_data[0], 128'h44444444_33333333_22222222_11111111);
`endif

    // Streaming 12 words, three lines spaced 4 cycles apart
    fill_rand(12);
    run_xfer(32'h10, 100, 1'b0);
    if (wq_cyc.size() == 3) begin
      chk("stream_spacing_1", wq_cyc[1] - wq_cyc[0], 4);
      chk("stream_spacing_2", wq_cyc[2] - wq_cyc[1], 4);
    end

    // Partial final line and zero count
    fill_rand(6);
    run_xfer(32'h200, 100, 1'b0);
    words.delete();
    run_xfer(32'h300, 100, 1'b0);

    // Random valid with a stray start mid-transfer
    fill_rand(8);
    run_xfer(32'h1234, 50, 1'b1);
    for (int r = 0; r < 4; r++) begin
      fill_rand($urandom_range(1, 17));
      run_xfer($urandom, $urandom_range(30, 100), r[0]);
    end

    // Reset after 2 of 4 words
    fill_rand(4);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h40; num_words = 20'd4;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data = words[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_s_ready", s_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_wr_addr", wr_addr, 32'h0);
    chk("abort_data_in", data_in, 128'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", wq_addr.size(), 0);
    chk("abort_no_done", dq_cyc.size(), 0);
    $display("[TB] reset abort writes=%0d", wq_addr.size());
    @(negedge clk); rst_n = 1'b1;
    fill_rand(4);
    run_xfer(32'h40, 100, 1'b0);

    // Address wrap
    fill_rand(8);
    run_xfer(32'hFFFF_FFFF, 100, 1'b0);
    if (wq_addr.size() == 2) chk("wrap_second_addr", wq_addr[1], 32'h0);

    // Byte ordering of lane 0
    words = '{32'h01020304};
    run_xfer(32'h50, 100, 1'b0);
    if (wq_data.size() > 0) begin
`ifdef IFM_PACK_BYTE_SWAP_EN
      chk("byte_order_lane0", wq_data[0][31:0], 32'h04030201);
`else
      chk("byte_order_lane0", wq_data[0][31:0], 32'h01020304);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
